uart_rx_sipo: RTL and testbench

- Serial-in/parallel-out UART receiver; the receive-side counterpart of the TX serializer; consumes the serial line the TX stage drives.
- Samples the line with a 16x-oversampling enable and recovers start, 7/8 data bits, optional parity, and 1/2 stop bits.
- Frame configuration inputs use the same encoding as the TX side.
- Delivers a parallel byte with a one-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_rx_sipo_if.sv | 40 ++++
 rtl/uart_rx_sipo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sipo_if.sv
// UART receiver bundle: oversample enable, serial line, frame config
// and the parallel result with its strobe and error flags.
interface uart_rx_sipo_if;
  logic       sample_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       parity_error;
  logic       framing_error;

  modport master (
    output sample_tick,
    output rx_in,
    output parity_type,
    output stop_bits,
    output data_length,
    input  data_out,
    input  rx_valid,
    input  rx_busy,
    input  parity_error,
    input  framing_error
  );

  modport slave (
    input  sample_tick,
    input  rx_in,
    input  parity_type,
    input  stop_bits,
    input  data_length,
    output data_out,
    output rx_valid,
    output rx_busy,
    output parity_error,
    output framing_error
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start/7-8 data/parity/1-2 stop
// recovery into a parallel byte with parity and framing flags.
module uart_rx_sipo #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  uart_rx_sipo_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TMID =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TEND =
    TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          pbit_q, pbit_d;
  logic          fpend_q, fpend_d;
  logic          armed_q, armed_d;
  logic [1:0]    ptype_q, ptype_d;
  logic          stop2_q, stop2_d;
  logic          len8_q, len8_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  logic          tick_end;
  logic          par_en;
  logic [3:0]    last_bit;
  logic [7:0]    mask;
  logic          par_x;
  logic          perr_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= bus.rx_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick_end = (tick_q == TEND);
  assign par_en   = ptype_q[0] ^ ptype_q[1];
  assign last_bit = len8_q ? 4'd7 : 4'd6;
  assign mask     = len8_q ? 8'hff : 8'h7f;
  assign par_x    = (^(sh_q & mask)) ^ pbit_q;

  always_comb begin
    perr_calc = 1'b0;
    unique case (ptype_q)
      2'b01:   perr_calc = ~par_x;
      2'b10:   perr_calc = par_x;
      default: perr_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pbit_d  = pbit_q;
    fpend_d = fpend_q;
    armed_d = armed_q;
    ptype_d = ptype_q;
    stop2_d = stop2_q;
    len8_d  = len8_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    // Frame delivery runs on the first clk after the last stop sample.
    if (state_q == S_DONE) begin
      dout_d  = sh_q & mask;
      perr_d  = perr_calc;
      ferr_d  = fpend_q;
      valid_d = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end else if (bus.sample_tick) begin
      unique case (state_q)
        S_IDLE: begin
          tick_d  = '0;
          ptype_d = bus.parity_type;
          stop2_d = bus.stop_bits;
          len8_d  = bus.data_length;
          if (rx_s)
            armed_d = 1'b1;
          else if (armed_q)
            state_d = S_START;
        end
        S_START: begin
          if (tick_q == TMID) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              busy_d  = 1'b1;
              bit_d   = '0;
              sh_d    = '0;
              fpend_d = 1'b0;
              state_d = S_DATA;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_end) begin
            tick_d = '0;
            sh_d[bit_q[2:0]] = rx_s;
            if (bit_q == last_bit) begin
              bit_d   = '0;
              state_d = par_en ? S_PAR : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PAR: begin
          if (tick_end) begin
            tick_d  = '0;
            pbit_d  = rx_s;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_end) begin
            tick_d = '0;
            if (!rx_s)
              fpend_d = 1'b1;
            if (bit_q == {3'd0, stop2_q}) begin
              bit_d   = '0;
              armed_d = rx_s;
              state_d = S_DONE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      fpend_q <= 1'b0;
      armed_q <= 1'b0;
      ptype_q <= '0;
      stop2_q <= 1'b0;
      len8_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pbit_q  <= pbit_d;
      fpend_q <= fpend_d;
      armed_q <= armed_d;
      ptype_q <= ptype_d;
      stop2_q <= stop2_d;
      len8_q  <= len8_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.rx_valid      = valid_q;
  assign bus.rx_busy       = busy_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed frame table plus hand sequences for glitch, break,
// back-to-back frames and mid-frame reset.
module tb_uart_rx_sipo;

  localparam int OS   = 16;
  localparam int TDIV = 3;
  localparam int BITC = OS * TDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_sipo_if bus ();

  uart_rx_sipo #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    bus.sample_tick = (tdiv == 0);
  end

  logic [7:0] rxq[$];
  int busy_clks = 0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rxq.push_back(bus.data_out);
    if (bus.rx_busy === 1'b1) busy_clks++;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_tot++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (bus.sample_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic len8,
                            input logic [1:0] pt, input logic stop2,
                            input logic pb, input logic sv,
                            input int flip_at);
    int nb;
    bus.data_length = len8;
    bus.parity_type = pt;
    bus.stop_bits   = stop2;
    nb = len8 ? 8 : 7;
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i == flip_at) bus.data_length = ~bus.data_length;
      send_bit(d[i]);
    end
    if (pt == 2'b01 || pt == 2'b10) send_bit(pb);
    send_bit(sv);
    if (stop2) send_bit(sv);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       len8;
    logic [1:0] pt;
    logic       stop2;
    logic       pb;
    logic       sv;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int v0, b0, bits, np;
    vt[0] = '{8'hA5, 1, 2'b00, 0, 0, 1, 8'hA5, 0, 0};
    vt[1] = '{8'h41, 0, 2'b01, 1, 1, 1, 8'h41, 0, 0};
    vt[2] = '{8'h41, 0, 2'b01, 1, 0, 1, 8'h41, 1, 0};
    vt[3] = '{8'hFF, 1, 2'b10, 0, 0, 0, 8'hFF, 0, 1};
    vt[4] = '{8'h3C, 1, 2'b10, 0, 1, 1, 8'h3C, 1, 0};
    vt[5] = '{8'hC3, 0, 2'b11, 0, 0, 1, 8'h43, 0, 0};
    vt[6] = '{8'h00, 1, 2'b01, 1, 1, 1, 8'h00, 0, 0};
    vt[7] = '{8'h96, 1, 2'b10, 1, 0, 1, 8'h96, 0, 0};
    vt[8] = '{8'h5A, 1, 2'b00, 1, 0, 0, 8'h5A, 0, 1};

    bus.rx_in       = 1'b1;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.data_length = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_busy", bus.rx_busy, 1'b0);
    chk("rst_perr", bus.parity_error, 1'b0);
    chk("rst_ferr", bus.framing_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);

    for (int k = 0; k < 9; k++) begin
      v0 = rxq.size();
      b0 = busy_clks;
      send_frame(vt[k].d, vt[k].len8, vt[k].pt, vt[k].stop2,
                 vt[k].pb, vt[k].sv, -1);
      bus.rx_in = 1'b1;
      wait_ticks(OS);
      np = (vt[k].pt == 2'b01 || vt[k].pt == 2'b10) ? 1 : 0;
      bits = (vt[k].len8 ? 8 : 7) + np + (vt[k].stop2 ? 2 : 1);
      chk($sformatf("v%0d_count", k), rxq.size(), v0 + 1);
      chk($sformatf("v%0d_data", k), bus.data_out, vt[k].exp_d);
      chk($sformatf("v%0d_perr", k), bus.parity_error, vt[k].exp_pe);
      chk($sformatf("v%0d_ferr", k), bus.framing_error, vt[k].exp_fe);
      chk($sformatf("v%0d_busy_end", k), bus.rx_busy, 1'b0);
      chk_rng($sformatf("v%0d_busy_len", k), busy_clks - b0,
              bits * BITC - 6, bits * BITC + 6);
    end

    // Short low glitch on an idle line
    v0 = rxq.size();
    b0 = busy_clks;
    bus.rx_in = 1'b0;
    wait_ticks(5);
    bus.rx_in = 1'b1;
    wait_ticks(40);
    chk("glitch_count", rxq.size(), v0);
    chk("glitch_busy", busy_clks - b0, 0);

    // Framing error followed by a held-low break
    v0 = rxq.size();
    send_frame(8'hFF, 1, 2'b10, 0, 0, 0, -1);
    bus.rx_in = 1'b0;
    wait_ticks(3 * 11 * OS);
    chk("brk_count", rxq.size(), v0 + 1);
    chk("brk_data", bus.data_out, 8'hFF);
    chk("brk_ferr", bus.framing_error, 1'b1);
    chk("brk_busy", bus.rx_busy, 1'b0);
    bus.rx_in = 1'b1;
    wait_ticks(OS);
    send_frame(8'hA5, 1, 2'b00, 0, 0, 1, -1);
    wait_ticks(OS);
    chk("brk_next_count", rxq.size(), v0 + 2);
    chk("brk_next_data", bus.data_out, 8'hA5);
    chk("brk_next_ferr", bus.framing_error, 1'b0);

    // Back-to-back frames, data_length flipped inside the second
    v0 = rxq.size();
    send_frame(8'h12, 1, 2'b00, 0, 0, 1, -1);
    send_frame(8'h34, 1, 2'b00, 0, 0, 1, 3);
    bus.rx_in = 1'b1;
    wait_ticks(OS);
    chk("b2b_count", rxq.size(), v0 + 2);
    if (rxq.size() >= v0 + 2) begin
      chk("b2b_first", rxq[v0], 8'h12);
      chk("b2b_second", rxq[v0+1], 8'h34);
    end
    chk("b2b_ferr", bus.framing_error, 1'b0);
    chk("b2b_perr", bus.parity_error, 1'b0);

    // Reset in the middle of frame 0x55
    v0 = rxq.size();
    bus.data_length = 1'b1;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    bus.rx_in = 1'b1;
    wait_ticks(OS / 2);
    chk("mid_busy_pre", bus.rx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", bus.data_out, 8'h00);
    chk("mid_rst_valid", bus.rx_valid, 1'b0);
    chk("mid_rst_busy", bus.rx_busy, 1'b0);
    chk("mid_rst_perr", bus.parity_error, 1'b0);
    chk("mid_rst_ferr", bus.framing_error, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);
    chk("mid_no_valid", rxq.size(), v0);
    send_frame(8'h3C, 1, 2'b00, 0, 0, 1, -1);
    wait_ticks(OS);
    chk("post_rst_count", rxq.size(), v0 + 1);
    chk("post_rst_data", bus.data_out, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
